// File: rtl/lift_pkg.sv
// lift_pkg: shared widths, defaults and state encoding for the lift scheduler
package lift_pkg;
  localparam int FLOOR_W = 4;
  localparam int NUM_FLOORS_DEF = 15;
  localparam int FLOOR_SPAN = 1 << FLOOR_W;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} lift_state_t;
endpackage

// File: rtl/lift_pending_search.sv
// lift_pending_search: nearest pending floor strictly above and strictly below cur_floor
module lift_pending_search
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    next_above,
  output logic [FLOOR_W-1:0]    next_below,
  output logic                  found_above,
  output logic                  found_below
);
  always_comb begin
    found_above = 1'b0;
    next_above  = '0;
    found_below = 1'b0;
    next_below  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && i > int'(cur_floor)) begin
        found_above = 1'b1;
        next_above  = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && i < int'(cur_floor)) begin
        found_below = 1'b1;
        next_below  = FLOOR_W'(i);
      end
  end
endmodule

// File: rtl/lift_request_scheduler.sv
// lift_request_scheduler: SCAN-style lift request scheduler with door dwell timing
// Optional emergency recall to floor 0 is enabled by defining LIFT_SCHED_EMERGENCY_EN.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter int DWELL_TICKS = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
`ifdef LIFT_SCHED_EMERGENCY_EN
  input  logic                  emergency,
`endif
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  busy,
  output logic                  req_err
);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_TICKS - 1);
  lift_state_t state, state_n, resume;
  logic [FLOOR_W-1:0] next_above, next_below, target_n, up_dist, down_dist;
  logic found_above, found_below, at_cur, req_ok, door_reload, emg;
  logic [FLOOR_SPAN-1:0] pend_x;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic [31:0] dwell;

  lift_pending_search #(.NUM_FLOORS(NUM_FLOORS)) u_search (
    .pending     (pending),
    .cur_floor   (cur_floor),
    .next_above  (next_above),
    .next_below  (next_below),
    .found_above (found_above),
    .found_below (found_below)
  );

`ifdef LIFT_SCHED_EMERGENCY_EN
  logic emg_q;
  assign emg = emergency;
  always_ff @(posedge clk or posedge rst)
    if (rst) emg_q <= 1'b0;
    else emg_q <= emergency;
`else
  assign emg = 1'b0;
`endif

  // padded copy so an out-of-range cur_floor reads as "not pending"
  assign pend_x      = FLOOR_SPAN'(pending);
  assign at_cur      = pend_x[cur_floor];
  assign up_dist     = next_above - cur_floor;
  assign down_dist   = cur_floor - next_below;
  assign req_ok      = req_valid && int'(req_floor) < NUM_FLOORS && !emg;
  assign door_reload = state == DOOR && req_ok && req_floor == cur_floor;
  assign set_mask    = (req_ok && !door_reload) ? NUM_FLOORS'(1) << req_floor : '0;
  assign clr_mask    = (state_n == DOOR && state != DOOR) ? NUM_FLOORS'(1) << cur_floor : '0;

  always_comb begin
    resume  = dir_up ? (found_above ? MOVE_UP : found_below ? MOVE_DOWN : IDLE)
                     : (found_below ? MOVE_DOWN : found_above ? MOVE_UP : IDLE);
    state_n = state;
    case (state)
      IDLE:      state_n = at_cur ? DOOR
                         : (found_above && (!found_below || up_dist <= down_dist)) ? MOVE_UP
                         : found_below ? MOVE_DOWN : IDLE;
      MOVE_UP,
      MOVE_DOWN: state_n = at_cur ? DOOR : resume;
      DOOR:      state_n = (door_reload || dwell != DWELL_LAST) ? DOOR : resume;
    endcase
`ifdef LIFT_SCHED_EMERGENCY_EN
    if (emergency) state_n = cur_floor == '0 ? DOOR : MOVE_DOWN;
    else if (emg_q) state_n = IDLE;
`endif
  end

  assign target_n = emg ? '0
                  : state_n == MOVE_UP   ? next_above
                  : state_n == MOVE_DOWN ? next_below
                  : state_n == DOOR      ? cur_floor : target_floor;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      target_floor <= '0;
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
      busy         <= 1'b0;
      req_err      <= 1'b0;
      dwell        <= '0;
    end else begin
      state        <= state_n;
      pending      <= emg ? '0 : (pending | set_mask) & ~clr_mask;
      target_floor <= target_n;
      dir_up       <= emg ? 1'b0 : state_n == MOVE_UP ? 1'b1 : state_n == MOVE_DOWN ? 1'b0 : dir_up;
      door_open    <= state_n == DOOR;
      busy         <= state_n != IDLE;
      req_err      <= req_valid && (int'(req_floor) >= NUM_FLOORS || emg);
      dwell        <= (state_n == DOOR && (state != DOOR || door_reload)) ? '0
                    : (state == DOOR && dwell != DWELL_LAST) ? dwell + 32'd1 : dwell;
    end
endmodule

// File: tb/tb_lift_request_scheduler.sv
// tb_lift_request_scheduler: table-driven directed checks plus reset/emergency sequences
module tb_lift_request_scheduler;
  localparam int NF = 15;
  localparam int DW = 4;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [3:0] req_floor = '0, cur_floor = '0, target_floor;
  logic [NF-1:0] pending;
  logic dir_up, door_open, busy, req_err;
`ifdef LIFT_SCHED_EMERGENCY_EN
  logic emergency = 1'b0;
`endif
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  lift_request_scheduler #(.NUM_FLOORS(NF), .DWELL_TICKS(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .cur_floor    (cur_floor),
`ifdef LIFT_SCHED_EMERGENCY_EN
    .emergency    (emergency),
`endif
    .target_floor (target_floor),
    .pending      (pending),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .busy         (busy),
    .req_err      (req_err)
  );

  typedef struct {
    logic rv; logic [3:0] rf; logic [3:0] cf; logic [3:0] t; logic [14:0] p;
    logic du; logic d; logic b; logic e;
  } vec_t;
  vec_t v[$];

  task automatic add(input int n, input logic rv, input logic [3:0] rf, input logic [3:0] cf,
                     input logic [3:0] t, input logic [14:0] p, input logic du, d, b, e);
    for (int k = 0; k < n; k++) v.push_back('{rv, rf, cf, t, p, du, d, b, e});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] t, input logic [14:0] p,
                         input logic du, d, b, e);
    chk({tag, ".target"}, 32'(target_floor), 32'(t));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
    chk({tag, ".dir_up"}, 32'(dir_up), 32'(du));
    chk({tag, ".door_open"}, 32'(door_open), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".req_err"}, 32'(req_err), 32'(e));
  endtask

  task automatic step(input logic rv, input logic [3:0] rf, input logic [3:0] cf);
    req_valid = rv;
    req_floor = rf;
    cur_floor = cf;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    // request 5 from floor 0; request 5 again on the arrival edge (clear wins)
    add(1, 1, 5, 0, 0, 'h020, 1, 0, 0, 0);
    add(1, 0, 0, 0, 5, 'h020, 1, 0, 1, 0);
    add(1, 0, 0, 3, 5, 'h020, 1, 0, 1, 0);
    add(1, 1, 5, 5, 5, 'h000, 1, 1, 1, 0);
    add(3, 0, 0, 5, 5, 'h000, 1, 1, 1, 0);
    add(1, 0, 0, 5, 5, 'h000, 1, 0, 0, 0);
    // {8,1} from floor 6: up to 8, bad floor 15, dwell restart, reverse to 1
    add(1, 1, 8, 6, 5, 'h100, 1, 0, 0, 0);
    add(1, 1, 1, 6, 8, 'h102, 1, 0, 1, 0);
    add(1, 0, 0, 7, 8, 'h102, 1, 0, 1, 0);
    add(1, 0, 0, 8, 8, 'h002, 1, 1, 1, 0);
    add(1, 1, 15, 8, 8, 'h002, 1, 1, 1, 1);
    add(1, 1, 8, 8, 8, 'h002, 1, 1, 1, 0);
    add(3, 0, 0, 8, 8, 'h002, 1, 1, 1, 0);
    add(1, 0, 0, 8, 1, 'h002, 0, 0, 1, 0);
    add(1, 0, 0, 4, 1, 'h002, 0, 0, 1, 0);
    add(4, 0, 0, 1, 1, 'h000, 0, 1, 1, 0);
    add(1, 0, 0, 1, 1, 'h000, 0, 0, 0, 0);
    // heading to 9 from 2, intermediate request 4 picked up en route
    add(1, 1, 9, 2, 1, 'h200, 0, 0, 0, 0);
    add(1, 0, 0, 2, 9, 'h200, 1, 0, 1, 0);
    add(1, 1, 4, 2, 9, 'h210, 1, 0, 1, 0);
    add(1, 0, 0, 3, 4, 'h210, 1, 0, 1, 0);
    add(4, 0, 0, 4, 4, 'h200, 1, 1, 1, 0);
    add(1, 0, 0, 4, 9, 'h200, 1, 0, 1, 0);
    add(4, 0, 0, 9, 9, 'h000, 1, 1, 1, 0);
    add(1, 0, 0, 9, 9, 'h000, 1, 0, 0, 0);
    // downward trip from IDLE
    add(1, 1, 7, 9, 9, 'h080, 1, 0, 0, 0);
    add(1, 0, 0, 9, 7, 'h080, 0, 0, 1, 0);
    add(4, 0, 0, 7, 7, 'h000, 0, 1, 1, 0);
    add(1, 0, 0, 7, 7, 'h000, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 0, 'h000, 1, 0, 0, 0);
    foreach (v[i]) begin
      step(v[i].rv, v[i].rf, v[i].cf);
      chk_all($sformatf("vec%0d", i), v[i].t, v[i].p, v[i].du, v[i].d, v[i].b, v[i].e);
    end

    // asynchronous reset in the middle of a dwell with {3,7} outstanding
    step(1, 5, 5);
    step(0, 0, 5);
    chk("dwell.door_open", 32'(door_open), 32'd1);
    step(1, 3, 5);
    step(1, 7, 5);
    chk("dwell.pending", 32'(pending), 32'h088);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 'h000, 1, 0, 0, 0);
    #1 rst = 1'b0;
    step(0, 0, 5);
    chk_all("post_rst", 0, 'h000, 1, 0, 0, 0);

`ifdef LIFT_SCHED_EMERGENCY_EN
    step(1, 9, 6);
    step(0, 0, 6);
    chk_all("emg.pre", 9, 'h200, 1, 0, 1, 0);
    emergency = 1'b1;
    step(0, 0, 6);
    chk_all("emg.recall", 0, 'h000, 0, 0, 1, 0);
    step(0, 0, 0);
    chk_all("emg.floor0", 0, 'h000, 0, 1, 1, 0);
    step(1, 3, 0);
    chk_all("emg.reject", 0, 'h000, 0, 1, 1, 1);
    repeat (DW + 2) step(0, 0, 0);
    chk_all("emg.hold", 0, 'h000, 0, 1, 1, 0);
    emergency = 1'b0;
    step(0, 0, 0);
    chk_all("emg.release", 0, 'h000, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
